// File: rtl/multiplier_restore_unsigned.sv
// Run-to-completion unsigned shift-add multiplier that reconstructs a dividend
// from a (quotient, divisor, remainder) triple: result = arg0*arg1 + arg2.
// Also reports whether the result fits in WID0 bits and whether the remainder
// is a legal one for the divisor. Fixed latency: WID1 multiply steps plus one
// add step after the capture edge.
module multiplier_restore_unsigned #(
    parameter int WID0 = 32,
    parameter int WID1 = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vldin,
    input  logic [WID0-1:0]      arg0,
    input  logic [WID1-1:0]      arg1,
    input  logic [WID1-1:0]      arg2,
    output logic                 busy,
    output logic                 vldout,
    output logic [WID0+WID1-1:0] result,
    output logic                 fits,
    output logic                 rem_ok
);

    localparam int RW = WID0 + WID1;
    localparam int CW = (WID1 > 1) ? $clog2(WID1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WID1 - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD
    } state_e;

    state_e          state_q,  state_d;
    logic [WID0-1:0] mcand_q,  mcand_d;   // quotient, shifted in by cnt
    logic [WID1-1:0] mplr_q,   mplr_d;    // divisor, consumed LSB first
    logic [WID1-1:0] div_q,    div_d;     // unshifted divisor for rem_ok
    logic [WID1-1:0] rem_q,    rem_d;
    logic [RW-1:0]   acc_q,    acc_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            busy_q,   busy_d;
    logic            vldout_q, vldout_d;
    logic [RW-1:0]   result_q, result_d;
    logic            fits_q,   fits_d;
    logic            rem_ok_q, rem_ok_d;
    logic [RW-1:0]   sum;

    // Next-state and datapath: capture, one partial product per MUL edge, final add.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        div_d    = div_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        vldout_d = 1'b0;
        result_d = result_q;
        fits_d   = fits_q;
        rem_ok_d = rem_ok_q;
        sum      = acc_q + RW'(rem_q);

        case (state_q)
            IDLE: begin
                if (vldin) begin
                    mcand_d = arg0;
                    mplr_d  = arg1;
                    div_d   = arg1;
                    rem_d   = arg2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                // No early exit on a zero multiplier: latency stays fixed.
                if (mplr_q[0]) begin
                    acc_d = acc_q + (RW'(mcand_q) << cnt_q);
                end
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                result_d = sum;
                fits_d   = (sum[RW-1:WID0] == '0);
                rem_ok_d = (div_q != '0) && (rem_q < div_q);
                vldout_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; asynchronous reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            vldout_q <= 1'b0;
            result_q <= '0;
            fits_q   <= 1'b0;
            rem_ok_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the
            // values present before the edge, independent of statement order.
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            vldout_q <= vldout_d;
            result_q <= result_d;
            fits_q   <= fits_d;
            rem_ok_q <= rem_ok_d;
        end
    end

    assign busy   = busy_q;
    assign vldout = vldout_q;
    assign result = result_q;
    assign fits   = fits_q;
    assign rem_ok = rem_ok_q;

endmodule

// File: tb/tb_multiplier_restore_unsigned.sv
// Self-checking bench for multiplier_restore_unsigned: scoreboard of expected
// results filled by the driver, drained by a monitor on every vldout pulse.
module tb_multiplier_restore_unsigned;

    localparam int WID0 = 32;
    localparam int WID1 = 16;
    localparam int RW   = WID0 + WID1;
    localparam int LAT  = WID1 + 1;

    typedef struct {
        logic [RW-1:0] result;
        logic          fits;
        logic          rem_ok;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vldin;
    logic [WID0-1:0] arg0;
    logic [WID1-1:0] arg1;
    logic [WID1-1:0] arg2;
    logic            busy;
    logic            vldout;
    logic [RW-1:0]   result;
    logic            fits;
    logic            rem_ok;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_vld    = 0;
    logic prev_vld = 1'b0;

    multiplier_restore_unsigned #(.WID0(WID0), .WID1(WID1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .vldin  (vldin),
        .arg0   (arg0),
        .arg1   (arg1),
        .arg2   (arg2),
        .busy   (busy),
        .vldout (vldout),
        .result (result),
        .fits   (fits),
        .rem_ok (rem_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one request; caller is at a negedge. Returns at the next negedge.
    task automatic start_job(input logic [WID0-1:0] a0, input logic [WID1-1:0] a1,
                             input logic [WID1-1:0] a2, input bit accept);
        logic [RW-1:0] res;
        exp_t e;
        check("busy_at_request", busy, !accept);
        res = RW'(a0) * RW'(a1) + RW'(a2);
        e.result = res;
        e.fits   = (res[RW-1:WID0] == '0);
        e.rem_ok = (a1 != 0) && (a2 < a1);
        if (accept) sb.push_back(e);
        vldin = 1'b1;
        arg0  = a0;
        arg1  = a1;
        arg2  = a2;
        @(negedge clk);
        vldin = 1'b0;
        arg0  = $urandom;
        arg1  = WID1'($urandom);
        arg2  = WID1'($urandom);
    endtask

    // Count negedges until vldout is seen, bounded.
    task automatic wait_vldout(output int n);
        n = 0;
        while (!vldout && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!vldout) check("vldout_timeout", 0, 1);
    endtask

    // Wait until the scoreboard drains, bounded.
    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("idle_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: every vldout pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vldout) begin
                exp_t e;
                n_vld++;
                check("vldout_one_cycle", prev_vld, 0);
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", result, e.result);
                    check("fits", fits, e.fits);
                    check("rem_ok", rem_ok, e.rem_ok);
                end
            end
            prev_vld = vldout;
        end else begin
            prev_vld = 1'b0;
        end
    end

    initial begin
        int lat;
        int v0;
        rst_n = 1'b0;
        vldin = 1'b0;
        arg0  = '0;
        arg1  = '0;
        arg2  = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_vldout", vldout, 0);
        check("rst_result", result, 0);
        check("rst_fits", fits, 0);
        check("rst_rem_ok", rem_ok, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job with cycle-accurate busy/vldout timing.
        start_job(14, 7, 2, 1);
        check("basic_busy_c0", busy, 1);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            check("basic_busy", busy, 1);
            check("basic_no_vldout", vldout, 0);
        end
        @(negedge clk);
        check("basic_vldout", vldout, 1);
        check("basic_busy_done", busy, 0);
        check("basic_value", result, 100);
        @(negedge clk);
        check("basic_vldout_drop", vldout, 0);
        check("basic_hold", result, 100);
        wait_idle();

        // Max operands and illegal triples.
        start_job(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFE, 1);
        wait_idle();
        check("max_value", result, 48'hFFFE_FFFF_FFFF);
        start_job(5, 0, 3, 1);
        wait_idle();
        start_job(1, 4, 4, 1);
        wait_idle();

        // Request while busy is ignored; request in vldout cycle is accepted.
        v0 = n_vld;
        start_job(3, 3, 0, 1);
        repeat (3) @(negedge clk);
        start_job(9, 9, 0, 0);
        wait_vldout(lat);
        check("hs_first_value", result, 9);
        start_job(2, 5, 1, 1);
        wait_vldout(lat);
        check("b2b_latency", lat, LAT);
        check("b2b_value", result, 11);
        repeat (25) @(negedge clk);
        check("hs_vldout_count", n_vld - v0, 2);

        // Reset in the middle of a job.
        start_job(10, 10, 0, 1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_vldout", vldout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_vld;
        repeat (30) @(negedge clk);
        check("midrst_no_vldout", n_vld - v0, 0);
        start_job(6, 7, 5, 1);
        wait_idle();
        check("post_rst_value", result, 47);

        // Random triples against the arithmetic model.
        for (int i = 0; i < 100; i++) begin
            start_job($urandom, WID1'($urandom), WID1'($urandom), 1);
            wait_idle();
        end

        // Closed loop: divide a random dividend, feed quotient/divisor/remainder
        // back and expect the dividend, fits=1, rem_ok=1.
        for (int i = 0; i < 300; i++) begin
            logic [WID0-1:0] d;
            logic [WID0-1:0] q;
            logic [WID1-1:0] dv;
            logic [WID1-1:0] r;
            d  = $urandom;
            dv = WID1'($urandom_range(1, (1 << WID1) - 1));
            q  = d / WID0'(dv);
            r  = WID1'(d % WID0'(dv));
            start_job(q, dv, r, 1);
            wait_idle();
            check("loop_dividend", result, RW'(d));
            check("loop_fits", fits, 1);
            check("loop_rem_ok", rem_ok, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
